// File: rtl/button_repeater.sv
// button_repeater: synchroniser + debouncer + press/auto-repeat FSM for one
// front-panel push-button. Emits a one-cycle Press on the debounced press and
// on each auto-repeat, a one-cycle Release on the debounced release, and Held
// while auto-repeat is active.
module button_repeater #(
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Input,
    input  logic RepeatEn,
    output logic Level,
    output logic Press,
    output logic Release,
    output logic Held
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_e;

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             rise, fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             hold_due, repeat_due;

    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             held_q, held_d;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= Input;
            s2_q <= s1_q;
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip Level on the last one.
    // rise/fall are the flip events seen by the FSM in the same cycle Level moves.
    always_comb begin
        level_d = level_q;
        dcnt_d  = '0;
        rise    = 1'b0;
        fall    = 1'b0;
        if (s2_q != level_q) begin
            if (dcnt_q == STABLE_LAST) begin
                level_d = s2_q;
                rise    = s2_q;
                fall    = ~s2_q;
            end else begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            level_q <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign hold_due   = (rcnt_q == HOLD_LAST);
    assign repeat_due = (rcnt_q == REPEAT_LAST);

    // FSM state and repeat counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // FSM next state: a release beats everything; dropping RepeatEn beats a due repeat.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        if (fall) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rcnt_d = '0;
                    if (rise) begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!RepeatEn) begin
                        rcnt_d = '0;
                    end else if (hold_due) begin
                        state_d = ST_REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!RepeatEn) begin
                        state_d = ST_PRESSED;
                        rcnt_d  = '0;
                    end else if (repeat_due) begin
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    // FSM outputs (next-cycle values); Press is suppressed whenever Release fires.
    always_comb begin
        press_d   = 1'b0;
        release_d = fall;
        held_d    = (state_d == ST_REPEAT);
        if (!fall) begin
            case (state_q)
                ST_IDLE:    press_d = rise;
                ST_PRESSED: press_d = RepeatEn & hold_due;
                ST_REPEAT:  press_d = RepeatEn & repeat_due;
                default:    press_d = 1'b0;
            endcase
        end
    end

    // Registered outputs so every port is glitch-free.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

    assign Level   = level_q;
    assign Press   = press_q;
    assign Release = release_q;
    assign Held    = held_q;

endmodule

// File: tb/tb_button_repeater.sv
// Testbench for button_repeater with STABLE=4, HOLD=20, REPEAT=8.
module tb_button_repeater;

    localparam int STABLE = 4;
    localparam int HOLD   = 20;
    localparam int REPEAT = 8;

    logic Clk = 1'b0;
    logic Reset;
    logic Input;
    logic RepeatEn;
    logic Level, Press, Release, Held;

    button_repeater #(
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REPEAT),
        .CNT_W        (8)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Input   (Input),
        .RepeatEn(RepeatEn),
        .Level   (Level),
        .Press   (Press),
        .Release (Release),
        .Held    (Held)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tcount  = 0;
    int press_log[$];
    int rel_log[$];
    int level_hi = 0;

    // ---------------- behavioural reference model ----------------
    // Level flips once the last STABLE synchronised samples (the raw sample
    // taken two edges earlier and before) all disagree with it. Repeats are
    // tracked as absolute deadlines (edge numbers), not counters.
    bit     hist[$];
    bit     m_level = 1'b0;
    int     m_state = 0;      // 0 idle, 1 pressed, 2 repeat
    longint m_edge  = 0;
    longint m_due   = -1;
    bit     m_press = 1'b0, m_release = 1'b0, m_held = 1'b0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hist.delete();
            for (int k = 0; k <= STABLE; k++) hist.push_back(1'b0);
            m_level = 1'b0; m_state = 0; m_due = -1;
            m_press = 1'b0; m_release = 1'b0; m_held = 1'b0;
        end else begin
            bit flip, rise_m, fall_m;
            m_edge++;
            flip = 1'b1;
            for (int k = 0; k < STABLE; k++) if (hist[k] == m_level) flip = 1'b0;
            hist.push_back(Input);
            void'(hist.pop_front());
            rise_m = flip && !m_level;
            fall_m = flip && m_level;
            if (flip) m_level = ~m_level;
            m_press = 1'b0;
            m_release = 1'b0;
            if (fall_m) begin
                m_release = 1'b1; m_state = 0; m_due = -1;
            end else if (m_state == 0) begin
                if (rise_m) begin m_press = 1'b1; m_state = 1; m_due = -1; end
            end else if (m_state == 1) begin
                if (!RepeatEn) m_due = -1;
                else begin
                    if (m_due < 0) m_due = m_edge + HOLD - 1;
                    if (m_edge == m_due) begin
                        m_press = 1'b1; m_state = 2; m_due = m_edge + REPEAT;
                    end
                end
            end else begin
                if (!RepeatEn) begin m_state = 1; m_due = -1; end
                else if (m_edge == m_due) begin m_press = 1'b1; m_due = m_edge + REPEAT; end
            end
            m_held = (m_state == 2);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; sample #1 after the edge, compare against the model and log pulses.
    task automatic tick();
        @(posedge Clk);
        #1;
        tcount++;
        if (Press === 1'b1) press_log.push_back(tcount);
        if (Release === 1'b1) rel_log.push_back(tcount);
        if (Level === 1'b1) level_hi++;
        n_tests++;
        if ({Level, Press, Release, Held} !== {m_level, m_press, m_release, m_held}) begin
            n_fail++;
            $display("FAIL model tick %0d: got LPRH=%b%b%b%b expected %b%b%b%b",
                     tcount, Level, Press, Release, Held, m_level, m_press, m_release, m_held);
        end
    endtask

    task automatic clear_logs();
        press_log.delete();
        rel_log.delete();
        level_hi = 0;
    endtask

    task automatic go_idle();
        Input = 1'b0;
        RepeatEn = 1'b0;
        repeat (12) tick();
        clear_logs();
    endtask

    typedef struct {
        bit       in;
        bit       en;
        bit [3:0] exp;   // {Level, Press, Release, Held}
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(bit in_v, bit en_v, bit [3:0] exp_v);
        vec_t v;
        v.in = in_v; v.en = en_v; v.exp = exp_v;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, len;
        bit bounce[7];

        // Clean press then release, one record per clock from the first capture edge.
        repeat (5) add_vec(1'b1, 1'b0, 4'b0000);   // edges 0..4
        add_vec(1'b1, 1'b0, 4'b1100);              // edge 5: Level + Press
        repeat (3) add_vec(1'b1, 1'b0, 4'b1000);   // edges 6..8
        repeat (5) add_vec(1'b0, 1'b0, 4'b1000);   // edge 9 captures the 0
        add_vec(1'b0, 1'b0, 4'b0010);              // edge 14: Release
        add_vec(1'b0, 1'b0, 4'b0000);

        Reset = 1'b1; Input = 1'b0; RepeatEn = 1'b0;
        repeat (3) tick();
        check("reset_outputs", int'({Level, Press, Release, Held}), 0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            Input = vecs[i].in;
            RepeatEn = vecs[i].en;
            tick();
            check($sformatf("vec%0d", i), int'({Level, Press, Release, Held}), int'(vecs[i].exp));
        end

        // 3-cycle glitch must be swallowed.
        go_idle();
        Input = 1'b1;
        repeat (3) tick();
        Input = 1'b0;
        repeat (12) tick();
        check("glitch_press", press_log.size(), 0);
        check("glitch_release", rel_log.size(), 0);
        check("glitch_level", level_hi, 0);

        // Bounce 1,0,1,1,1,1,1: one Press at the 8th clock after the first drive.
        go_idle();
        bounce = '{1, 0, 1, 1, 1, 1, 1};
        t0 = tcount;
        for (int i = 0; i < 7; i++) begin
            Input = bounce[i];
            tick();
        end
        repeat (10) tick();
        check("bounce_press_count", press_log.size(), 1);
        check("bounce_press_tick", press_log.size() > 0 ? press_log[0] - t0 : -1, 8);
        Input = 1'b0;
        t1 = tcount;
        repeat (8) tick();
        check("bounce_release_tick", rel_log.size() > 0 ? rel_log[0] - t1 : -1, 6);

        // Auto-repeat with release between repeats.
        go_idle();
        RepeatEn = 1'b1; Input = 1'b1;
        t0 = tcount;
        for (int r = 1; r <= 55; r++) begin
            tick();
            if (r == 25) check("rep_held_before", int'(Held), 0);
            if (r == 26) check("rep_held_rise", int'(Held), 1);
            if (r == 45) check("rep_held_hold", int'(Held), 1);
            if (r == 46) check("rep_release_held", int'({Release, Held}), 2);
            if (r == 40) Input = 1'b0;
        end
        check("rep_press_count", press_log.size(), 4);
        if (press_log.size() == 4) begin
            check("rep_p0", press_log[0] - t0, 6);
            check("rep_p1", press_log[1] - t0, 26);
            check("rep_p2", press_log[2] - t0, 34);
            check("rep_p3", press_log[3] - t0, 42);
        end
        check("rep_release_count", rel_log.size(), 1);

        // Release lands on the cycle a repeat is due: release wins.
        go_idle();
        RepeatEn = 1'b1; Input = 1'b1;
        t0 = tcount;
        for (int r = 1; r <= 45; r++) begin
            tick();
            if (r == 34) check("coll_RPH", int'({Release, Press, Held}), 4);
            if (r == 28) Input = 1'b0;
        end
        check("coll_press_count", press_log.size(), 2);
        check("coll_release_count", rel_log.size(), 1);

        // RepeatEn dropped in REPEAT, re-raised later.
        go_idle();
        RepeatEn = 1'b1; Input = 1'b1;
        t0 = tcount;
        for (int r = 1; r <= 70; r++) begin
            tick();
            if (r == 29) check("tog_held_fall", int'(Held), 0);
            if (r == 60) check("tog_repress_PH", int'({Press, Held}), 3);
            if (r == 28) RepeatEn = 1'b0;
            if (r == 40) RepeatEn = 1'b1;
            if (r == 60) Input = 1'b0;
        end
        check("tog_press_count", press_log.size(), 3);
        if (press_log.size() == 3) check("tog_p2", press_log[2] - t0, 60);

        // Asynchronous reset mid-hold, released with the button still down.
        go_idle();
        RepeatEn = 1'b1; Input = 1'b1;
        repeat (30) tick();
        check("rst_pre_held", int'(Held), 1);
        clear_logs();
        #2 Reset = 1'b1;
        #1 check("rst_async_zero", int'({Level, Press, Release, Held}), 0);
        repeat (3) tick();
        Reset = 1'b0;
        t1 = tcount;
        repeat (10) tick();
        check("rst_no_release", rel_log.size(), 0);
        check("rst_repress_tick", press_log.size() > 0 ? press_log[0] - t1 : -1, 6);

        // Randomised segments checked every clock against the model.
        go_idle();
        t0 = tcount;
        while (tcount < t0 + 4000) begin
            Input = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 60));
            if ($urandom_range(0, 3) == 0) RepeatEn = ~RepeatEn;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 29) == 0) RepeatEn = ~RepeatEn;
                tick();
            end
            if ($urandom_range(0, 24) == 0) begin
                Reset = 1'b1;
                tick();
                tick();
                Reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
